// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the LEGv8 datapath and hazard_ctrl.
// The datapath side (master) supplies stage register/control fields and the
// memory handshake; hazard_ctrl (slave) returns enables, flushes, forwarding
// selects, freeze and the performance counters.
interface hazard_ctrl_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
);
   // ID / EX / MEM / WB register fields
   logic [RA_W-1:0]  id_rn;
   logic [RA_W-1:0]  id_rm;
   logic             id_uses_rm;
   logic [RA_W-1:0]  ex_rn;
   logic [RA_W-1:0]  ex_rm;
   logic [RA_W-1:0]  ex_rd;
   logic             ex_memRead;
   logic [RA_W-1:0]  mem_rd;
   logic             mem_regWrite;
   logic [RA_W-1:0]  wb_rd;
   logic             wb_regWrite;
   // data-memory handshake and branch resolution
   logic             mem_access;
   logic             dm_ready;
   logic             branch_taken;
   // control outputs
   logic [1:0]       fwA;
   logic [1:0]       fwB;
   logic             PC_writeEnable;
   logic             IF_ID_writeEnable;
   logic             ID_EX_bubble;
   logic             flush_IF_ID;
   logic             flush_ID_EX;
   logic             flush_EX_MEM;
   logic             freeze;
   logic             hazard;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] wait_cnt;

   modport master (
      output id_rn, id_rm, id_uses_rm, ex_rn, ex_rm, ex_rd, ex_memRead,
             mem_rd, mem_regWrite, wb_rd, wb_regWrite,
             mem_access, dm_ready, branch_taken,
      input  fwA, fwB, PC_writeEnable, IF_ID_writeEnable, ID_EX_bubble,
             flush_IF_ID, flush_ID_EX, flush_EX_MEM, freeze, hazard,
             mem_timeout, stall_cnt, flush_cnt, wait_cnt
   );

   modport slave (
      input  id_rn, id_rm, id_uses_rm, ex_rn, ex_rm, ex_rd, ex_memRead,
             mem_rd, mem_regWrite, wb_rd, wb_regWrite,
             mem_access, dm_ready, branch_taken,
      output fwA, fwB, PC_writeEnable, IF_ID_writeEnable, ID_EX_bubble,
             flush_IF_ID, flush_ID_EX, flush_EX_MEM, freeze, hazard,
             mem_timeout, stall_cnt, flush_cnt, wait_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the five-stage LEGv8 core:
// EX operand forwarding, load-use stall, taken-branch flush, data-memory
// wait-state freeze with timeout fault, and saturating performance counters.
module hazard_ctrl #(
   parameter int RA_W     = 5,
   parameter int ZERO_REG = 31,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input logic           clk,
   input logic           reset,
   hazard_ctrl_if.slave  hif
);
   localparam int unsigned     WW = $clog2(MAX_WAIT + 1);
   localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_FAULT} state_t;

   state_t           state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic             mem_timeout_q;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [CNT_W-1:0] waitc_q, waitc_d;

   logic lu;
   logic mem_stall;
   logic freeze_c;

   // Forwarding selects: EX/MEM result wins over MEM/WB; XZR never forwards.
   always_comb begin
      hif.fwA = 2'b00;
      if (hif.ex_rn != ZR && hif.mem_regWrite && hif.mem_rd == hif.ex_rn)
         hif.fwA = 2'b10;
      else if (hif.ex_rn != ZR && hif.wb_regWrite && hif.wb_rd == hif.ex_rn)
         hif.fwA = 2'b01;
      hif.fwB = 2'b00;
      if (hif.ex_rm != ZR && hif.mem_regWrite && hif.mem_rd == hif.ex_rm)
         hif.fwB = 2'b10;
      else if (hif.ex_rm != ZR && hif.wb_regWrite && hif.wb_rd == hif.ex_rm)
         hif.fwB = 2'b01;
   end

   // Pipeline enables/flushes with priority freeze > branch > load-use.
   always_comb begin
      lu = hif.ex_memRead && hif.ex_rd != ZR &&
           (hif.ex_rd == hif.id_rn || (hif.id_uses_rm && hif.ex_rd == hif.id_rm));
      mem_stall = hif.mem_access && !hif.dm_ready;
      freeze_c  = mem_stall || state_q == S_FAULT;

      hif.PC_writeEnable    = 1'b1;
      hif.IF_ID_writeEnable = 1'b1;
      hif.ID_EX_bubble      = 1'b0;
      hif.flush_IF_ID       = 1'b0;
      hif.flush_ID_EX       = 1'b0;
      hif.flush_EX_MEM      = 1'b0;
      hif.freeze            = freeze_c;
      hif.hazard            = lu;

      if (freeze_c) begin
         hif.PC_writeEnable    = 1'b0;
         hif.IF_ID_writeEnable = 1'b0;
      end else if (hif.branch_taken) begin
         hif.flush_IF_ID  = 1'b1;
         hif.flush_ID_EX  = 1'b1;
         hif.flush_EX_MEM = 1'b1;
      end else if (lu) begin
         hif.PC_writeEnable    = 1'b0;
         hif.IF_ID_writeEnable = 1'b0;
         hif.ID_EX_bubble      = 1'b1;
      end
   end

   // Memory wait FSM. wait_q counts frozen cycles of the current access,
   // including the RUN cycle that started it, so MAX_WAIT+1 frozen cycles
   // lead to FAULT.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         S_RUN: begin
            wait_d = '0;
            if (mem_stall) begin
               state_d = S_WAIT;
               wait_d  = WW'(1);
            end
         end
         S_WAIT: begin
            if (!mem_stall) begin
               state_d = S_RUN;
               wait_d  = '0;
            end else if (wait_q == WW'(MAX_WAIT)) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_RUN;
            wait_d  = '0;
         end
      endcase
   end

   // Saturating performance counter next values.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      waitc_d = waitc_q;
      if (lu && !freeze_c && !hif.branch_taken && stall_q != '1)
         stall_d = stall_q + CNT_W'(1);
      if (hif.branch_taken && !freeze_c && flush_q != '1)
         flush_d = flush_q + CNT_W'(1);
      if (freeze_c && waitc_q != '1)
         waitc_d = waitc_q + CNT_W'(1);
   end

   // State, wait counter, sticky fault flag and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_RUN;
         wait_q        <= '0;
         mem_timeout_q <= 1'b0;
         stall_q       <= '0;
         flush_q       <= '0;
         waitc_q       <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         mem_timeout_q <= mem_timeout_q || state_d == S_FAULT;
         stall_q       <= stall_d;
         flush_q       <= flush_d;
         waitc_q       <= waitc_d;
      end
   end

   assign hif.mem_timeout = mem_timeout_q;
   assign hif.stall_cnt   = stall_q;
   assign hif.flush_cnt   = flush_q;
   assign hif.wait_cnt    = waitc_q;
endmodule
